// File: rtl/display_timing_pkg.sv
// Shared timing types, standard video modes and width helpers for the raster generator.
package display_timing_pkg;

  // One axis of a raster: region lengths plus the asserted sync level.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } timing_t;

  // A complete video mode, one timing_t per axis.
  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  localparam mode_t TIMING_480P60 = '{
    h: '{active: 640,  fp: 16,  sync: 96, bp: 48,  pol: 1'b0},
    v: '{active: 480,  fp: 10,  sync: 2,  bp: 33,  pol: 1'b0}
  };

  localparam mode_t TIMING_720P60 = '{
    h: '{active: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1},
    v: '{active: 720,  fp: 5,   sync: 5,  bp: 20,  pol: 1'b1}
  };

  // Total length of one axis (pixels per line or lines per frame).
  function automatic int unsigned total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_timing_axis.sv
// One raster axis: wrapping counter plus sync/blank/coordinate decode of the next count.
module timing_axis
  import display_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  localparam timing_t CFG = '{active: unsigned'(ACTIVE), fp: unsigned'(FP),
                              sync: unsigned'(SYNC), bp: unsigned'(BP), pol: POL},
  localparam int unsigned TOTAL = total(CFG),
  localparam int unsigned W     = cnt_width(TOTAL),
  localparam int unsigned PW    = cnt_width(CFG.active)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_i,
  output logic [W-1:0]  cnt_o,
  output logic          next_sync_c,
  output logic          next_blank_c,
  output logic [PW-1:0] next_pos_c,
  output logic          wrap_c
);

  localparam int unsigned START = CFG.sync + CFG.bp;
  localparam int unsigned STOP  = START + CFG.active;

  // Sync and active lengths must be nonzero; porches may be zero but not negative.
  if (SYNC <= 0 || ACTIVE <= 0 || FP < 0 || BP < 0) begin : g_bad_params
    $error("timing_axis: SYNC/ACTIVE must be > 0 and porches >= 0");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic [31:0]  cnt_ext;
  logic [W-1:0] offset;
  logic         active;

  // Next count: advance on step, wrap to zero after the last position.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_c = 1'b0;
    if (step_i) begin
      if (cnt_q == W'(TOTAL - 1)) begin
        cnt_d  = '0;
        wrap_c = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Decode from the next count so registered outputs line up with the counter.
  always_comb begin
    cnt_ext      = 32'(cnt_d);
    active       = (cnt_ext >= START) && (cnt_ext < STOP);
    offset       = cnt_d - W'(START);
    next_sync_c  = (cnt_ext < CFG.sync) ? POL : ~POL;
    next_blank_c = ~active;
    next_pos_c   = active ? PW'(offset) : '0;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/display_timing.sv
// Parametrised raster timing generator stepped by a pixel-rate clock enable.
module display_timing
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE   = int'(TIMING_480P60.h.active),
  parameter int H_FP       = int'(TIMING_480P60.h.fp),
  parameter int H_SYNC     = int'(TIMING_480P60.h.sync),
  parameter int H_BP       = int'(TIMING_480P60.h.bp),
  parameter int V_ACTIVE   = int'(TIMING_480P60.v.active),
  parameter int V_FP       = int'(TIMING_480P60.v.fp),
  parameter int V_SYNC     = int'(TIMING_480P60.v.sync),
  parameter int V_BP       = int'(TIMING_480P60.v.bp),
  parameter bit H_SYNC_POL = TIMING_480P60.h.pol,
  parameter bit V_SYNC_POL = TIMING_480P60.v.pol,
  localparam int unsigned HW = cnt_width(unsigned'(H_ACTIVE + H_FP + H_SYNC + H_BP)),
  localparam int unsigned VW = cnt_width(unsigned'(V_ACTIVE + V_FP + V_SYNC + V_BP)),
  localparam int unsigned XW = cnt_width(unsigned'(H_ACTIVE)),
  localparam int unsigned YW = cnt_width(unsigned'(V_ACTIVE))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          h_blank,
  output logic          v_blank,
  output logic          line_start,
  output logic          frame_start
);

  logic          h_wrap_c, v_wrap_c;
  logic          h_sync_d, v_sync_d, h_blank_d, v_blank_d;
  logic [XW-1:0] pos_x_d;
  logic [YW-1:0] pos_y_d;
  logic          de_d, line_start_d, frame_start_d;

  logic          h_sync_q, v_sync_q, h_blank_q, v_blank_q;
  logic [XW-1:0] pos_x_q;
  logic [YW-1:0] pos_y_q;
  logic          de_q, line_start_q, frame_start_q;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst),
    .step_i       (pix_en),
    .cnt_o        (h_cnt),
    .next_sync_c  (h_sync_d),
    .next_blank_c (h_blank_d),
    .next_pos_c   (pos_x_d),
    .wrap_c       (h_wrap_c)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst),
    .step_i       (pix_en & h_wrap_c),
    .cnt_o        (v_cnt),
    .next_sync_c  (v_sync_d),
    .next_blank_c (v_blank_d),
    .next_pos_c   (pos_y_d),
    .wrap_c       (v_wrap_c)
  );

  // Data enable and wrap strobes derived from the next-count decode.
  always_comb begin
    de_d          = ~h_blank_d & ~v_blank_d;
    line_start_d  = h_wrap_c;
    frame_start_d = h_wrap_c & v_wrap_c;
  end

  // Output registers; levels hold naturally while pix_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_sync_q      <= H_SYNC_POL;
      v_sync_q      <= V_SYNC_POL;
      h_blank_q     <= 1'b1;
      v_blank_q     <= 1'b1;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      h_blank_q     <= h_blank_d;
      v_blank_q     <= v_blank_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign h_blank     = h_blank_q;
  assign v_blank     = v_blank_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_timing.sv
// Directed, table-driven bench for display_timing in three modes: 480p default, a small
// mode with pix_en every third cycle, and a zero-porch mode.
module tb_display_timing;

  typedef struct {
    int h; int v; int px; int py;
    int hs; int vs; int de; int hb; int vb; int ls; int fs;
  } obs_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pe_def, pe_sml, pe_zro;

  logic [9:0] d_hc, d_vc, d_px;
  logic [8:0] d_py;
  logic d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs;

  logic [2:0] s_hc, s_vc;
  logic [1:0] s_px, s_py;
  logic s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs;

  logic [3:0] z_hc;
  logic [2:0] z_vc, z_px;
  logic [1:0] z_py;
  logic z_hs, z_vs, z_de, z_hb, z_vb, z_ls, z_fs;

  display_timing u_def (
    .clk(clk), .rst(rst), .pix_en(pe_def),
    .h_cnt(d_hc), .v_cnt(d_vc), .pos_x(d_px), .pos_y(d_py),
    .h_sync(d_hs), .v_sync(d_vs), .de(d_de), .h_blank(d_hb), .v_blank(d_vb),
    .line_start(d_ls), .frame_start(d_fs)
  );

  display_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_sml (
    .clk(clk), .rst(rst), .pix_en(pe_sml),
    .h_cnt(s_hc), .v_cnt(s_vc), .pos_x(s_px), .pos_y(s_py),
    .h_sync(s_hs), .v_sync(s_vs), .de(s_de), .h_blank(s_hb), .v_blank(s_vb),
    .line_start(s_ls), .frame_start(s_fs)
  );

  display_timing #(
    .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(0),
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(1), .V_BP(0)
  ) u_zro (
    .clk(clk), .rst(rst), .pix_en(pe_zro),
    .h_cnt(z_hc), .v_cnt(z_vc), .pos_x(z_px), .pos_y(z_py),
    .h_sync(z_hs), .v_sync(z_vs), .de(z_de), .h_blank(z_hb), .v_blank(z_vb),
    .line_start(z_ls), .frame_start(z_fs)
  );

  int   mode;
  obs_t obs;

  always_comb begin
    obs = '{default: 0};
    case (mode)
      0: obs = '{int'(d_hc), int'(d_vc), int'(d_px), int'(d_py), int'(d_hs), int'(d_vs),
                 int'(d_de), int'(d_hb), int'(d_vb), int'(d_ls), int'(d_fs)};
      1: obs = '{int'(s_hc), int'(s_vc), int'(s_px), int'(s_py), int'(s_hs), int'(s_vs),
                 int'(s_de), int'(s_hb), int'(s_vb), int'(s_ls), int'(s_fs)};
      default: obs = '{int'(z_hc), int'(z_vc), int'(z_px), int'(z_py), int'(z_hs), int'(z_vs),
                       int'(z_de), int'(z_hb), int'(z_vb), int'(z_ls), int'(z_fs)};
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input vec_t t, input string tag);
    chk($sformatf("%s@%0d h_cnt", tag, t.k),       obs.h,  t.e.h);
    chk($sformatf("%s@%0d v_cnt", tag, t.k),       obs.v,  t.e.v);
    chk($sformatf("%s@%0d pos_x", tag, t.k),       obs.px, t.e.px);
    chk($sformatf("%s@%0d pos_y", tag, t.k),       obs.py, t.e.py);
    chk($sformatf("%s@%0d h_sync", tag, t.k),      obs.hs, t.e.hs);
    chk($sformatf("%s@%0d v_sync", tag, t.k),      obs.vs, t.e.vs);
    chk($sformatf("%s@%0d de", tag, t.k),          obs.de, t.e.de);
    chk($sformatf("%s@%0d h_blank", tag, t.k),     obs.hb, t.e.hb);
    chk($sformatf("%s@%0d v_blank", tag, t.k),     obs.vb, t.e.vb);
    chk($sformatf("%s@%0d line_start", tag, t.k),  obs.ls, t.e.ls);
    chk($sformatf("%s@%0d frame_start", tag, t.k), obs.fs, t.e.fs);
  endtask

  // Small-mode tracking state, updated once per clk cycle by tick_small.
  int cyc, n_steps, prev_h, prev_ls, prev_fs;
  int ls_cnt, fs_cnt, ls_last, fs_last, per_err, wide_err, hold_err;

  task automatic tick_small(input bit en);
    pe_sml = en;
    @(negedge clk);
    cyc++;
    if (en) n_steps++;
    if (!en && int'(s_hc) != prev_h) hold_err++;
    if (en && int'(s_hc) == prev_h) hold_err++;
    prev_h = int'(s_hc);
    if (s_ls) begin
      if (prev_ls != 0) wide_err++;
      if (ls_last >= 0 && cyc - ls_last != 24) per_err++;
      ls_last = cyc;
      ls_cnt++;
    end
    if (s_fs) begin
      if (prev_fs != 0) wide_err++;
      if (fs_last >= 0 && cyc - fs_last != 144) per_err++;
      fs_last = cyc;
      fs_cnt++;
    end
    prev_ls = int'(s_ls);
    prev_fs = int'(s_fs);
  endtask

  vec_t rst_def, rst_sml;
  vec_t tbl_def[12];
  vec_t tbl_sml[10];
  vec_t tbl_zro[8];

  initial begin
    int k, idx, lsc, fsc, wide, pls, dec;

    // fields: h, v, pos_x, pos_y, h_sync, v_sync, de, h_blank, v_blank, line_start, frame_start
    rst_def = '{0, '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0}};
    rst_sml = '{0, '{0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0}};

    tbl_def = '{
      '{1,     '{1,   0,  0,   0, 0, 0, 0, 1, 1, 0, 0}},
      '{95,    '{95,  0,  0,   0, 0, 0, 0, 1, 1, 0, 0}},
      '{96,    '{96,  0,  0,   0, 1, 0, 0, 1, 1, 0, 0}},
      '{800,   '{0,   1,  0,   0, 0, 0, 0, 1, 1, 1, 0}},
      '{801,   '{1,   1,  0,   0, 0, 0, 0, 1, 1, 0, 0}},
      '{1600,  '{0,   2,  0,   0, 0, 1, 0, 1, 1, 1, 0}},
      '{28143, '{143, 35, 0,   0, 1, 1, 0, 1, 0, 0, 0}},
      '{28144, '{144, 35, 0,   0, 1, 1, 1, 0, 0, 0, 0}},
      '{28145, '{145, 35, 1,   0, 1, 1, 1, 0, 0, 0, 0}},
      '{28783, '{783, 35, 639, 0, 1, 1, 1, 0, 0, 0, 0}},
      '{28784, '{784, 35, 0,   0, 1, 1, 0, 1, 0, 0, 0}},
      '{28800, '{0,   36, 0,   1, 0, 1, 0, 1, 0, 1, 0}}
    };

    tbl_sml = '{
      '{1,  '{1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0}},
      '{2,  '{2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0}},
      '{4,  '{4, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0}},
      '{8,  '{0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0}},
      '{19, '{3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0}},
      '{22, '{6, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0}},
      '{23, '{7, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0}},
      '{38, '{6, 4, 3, 2, 0, 0, 1, 0, 0, 0, 0}},
      '{40, '{0, 5, 0, 0, 1, 0, 0, 1, 1, 1, 0}},
      '{48, '{0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1}}
    };

    tbl_zro = '{
      '{1,  '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0}},
      '{2,  '{2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0}},
      '{12, '{2, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0}},
      '{19, '{9, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0}},
      '{20, '{0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0}},
      '{49, '{9, 4, 7, 3, 1, 1, 1, 0, 0, 0, 0}},
      '{50, '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1}},
      '{52, '{2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0}}
    };

    // Reset held with pix_en toggling: every instance stays at its reset values.
    mode = 0; rst = 1'b0; pe_def = 1'b0; pe_sml = 1'b0; pe_zro = 1'b0;
    repeat (6) begin
      @(negedge clk);
      pe_def = ~pe_def; pe_sml = ~pe_sml; pe_zro = ~pe_zro;
    end
    @(negedge clk);
    mode = 0; #1; check_vec(rst_def, "rst_def");
    mode = 1; #1; check_vec(rst_sml, "rst_sml");
    mode = 2; #1; check_vec(rst_def, "rst_zro");
    pe_def = 1'b0; pe_sml = 1'b0; pe_zro = 1'b0;

    // Default 480p mode with pix_en held high.
    mode = 0;
    @(negedge clk);
    rst = 1'b1; pe_def = 1'b1;
    k = 0; lsc = 0; fsc = 0; wide = 0; pls = 0;
    for (int i = 0; i < 12; i++) begin
      while (k < tbl_def[i].k) begin
        @(negedge clk);
        k++;
        if (d_ls) begin lsc++; if (pls != 0) wide++; end
        if (d_fs) fsc++;
        pls = int'(d_ls);
      end
      check_vec(tbl_def[i], "def");
    end
    chk("def line_start count", lsc, 36);
    chk("def frame_start count", fsc, 0);
    chk("def line_start width", wide, 0);

    // Mid-line reset at h_cnt=300, v_cnt=36 takes effect without a clock edge.
    while (k < 29100) begin @(negedge clk); k++; end
    chk("def pre-reset h_cnt", int'(d_hc), 300);
    chk("def pre-reset v_cnt", int'(d_vc), 36);
    chk("def pre-reset de", int'(d_de), 1);
    chk("def pre-reset pos_x", int'(d_px), 156);
    chk("def pre-reset pos_y", int'(d_py), 1);
    rst = 1'b0;
    #1;
    check_vec(rst_def, "def_midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("def restart h_cnt", int'(d_hc), 1);
    chk("def restart v_cnt", int'(d_vc), 0);
    chk("def restart line_start", int'(d_ls), 0);
    pe_def = 1'b0;

    // Small mode with pix_en every third clk.
    mode = 1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc = 0; n_steps = 0; prev_h = 0; prev_ls = 0; prev_fs = 0;
    ls_cnt = 0; fs_cnt = 0; ls_last = -1; fs_last = -1;
    per_err = 0; wide_err = 0; hold_err = 0;
    idx = 0;
    for (int s = 0; s < 96; s++) begin
      tick_small(1'b1);
      if (idx < 10 && n_steps == tbl_sml[idx].k) begin
        check_vec(tbl_sml[idx], "sml");
        idx++;
      end
      tick_small(1'b0);
      tick_small(1'b0);
    end
    pe_sml = 1'b0;
    chk("sml vectors reached", idx, 10);
    chk("sml line_start count", ls_cnt, 12);
    chk("sml frame_start count", fs_cnt, 2);
    chk("sml strobe period errors", per_err, 0);
    chk("sml strobe width errors", wide_err, 0);
    chk("sml h_cnt enable errors", hold_err, 0);

    // Zero-porch mode with pix_en held high.
    mode = 2;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; pe_zro = 1'b1;
    k = 0; lsc = 0; fsc = 0; wide = 0; pls = 0; dec = 0;
    for (int i = 0; i < 8; i++) begin
      while (k < tbl_zro[i].k) begin
        @(negedge clk);
        k++;
        if (z_ls) begin lsc++; if (pls != 0) wide++; end
        if (z_fs) fsc++;
        if (z_de) dec++;
        pls = int'(z_ls);
      end
      check_vec(tbl_zro[i], "zro");
    end
    pe_zro = 1'b0;
    chk("zro line_start count", lsc, 5);
    chk("zro frame_start count", fsc, 1);
    chk("zro line_start width", wide, 0);
    chk("zro de cycle count", dec, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
